// File: rtl/id_pipe_stage.sv
// id_pipe_stage -- RISC-V instruction decode stage with a single ID/EX register.
//
// Decodes one RV32I/RV64I instruction (optionally the M extension) per
// cycle, reads the register file combinationally through rs1/rs2 address
// ports, and registers the decoded control word plus operands for the
// execute stage.  The output side is a valid/ready handshake; load-use
// hazards against the instruction currently in EX stall the input.
//
// Parameters:
//   XLEN   datapath width, 32 or 64
//   M_EXT  nonzero enables the multiply/divide decode
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   in_valid/in_ready            upstream handshake
//   in_inst, in_pc               instruction word and its pc
//   rs1_addr/rs2_addr            register file read addresses (0 if unused)
//   rs1_data/rs2_data            register file read data (combinational)
//   flush                        kill the stage contents
//   ex_is_load, ex_rd            instruction now in EX, for load-use stalls
//   out_valid/out_ready          downstream handshake
//   out_pc/op1/op2/imm           operands for EX
//   out_rd, out_rd_wen           destination register and write enable
//   out_alu_op                   ALU operation code
//   out_mem_rd/wr/size/unsigned  memory access control
//   out_word                     32-bit (W) operation on RV64
//   out_bj                       one-hot {jal,jalr,bgeu,bltu,bge,blt,bne,beq}
//   out_illegal                  illegal instruction flag
module id_pipe_stage #(
    parameter int XLEN  = 64,
    parameter int M_EXT = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    input  logic            ex_is_load,
    input  logic [4:0]      ex_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rd,
    output logic            out_rd_wen,
    output logic [4:0]      out_alu_op,
    output logic            out_mem_rd,
    output logic            out_mem_wr,
    output logic [1:0]      out_mem_size,
    output logic            out_mem_unsigned,
    output logic            out_word,
    output logic [7:0]      out_bj,
    output logic            out_illegal
);

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_FENCE    = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLT  = 5'd2;
    localparam logic [4:0] ALU_SLTU = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_OR   = 5'd5;
    localparam logic [4:0] ALU_AND  = 5'd6;
    localparam logic [4:0] ALU_SLL  = 5'd7;
    localparam logic [4:0] ALU_SRL  = 5'd8;
    localparam logic [4:0] ALU_SRA  = 5'd9;
    localparam logic [4:0] ALU_MUL  = 5'd10;

    typedef enum logic [1:0] {OP1_RS1, OP1_PC, OP1_ZERO} op1_sel_t;
    typedef enum logic [1:0] {OP2_IMM, OP2_RS2, OP2_LINK} op2_sel_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign funct7 = in_inst[31:25];

    // Immediates are built at 64 bits and truncated, so the same
    // expressions serve both widths without zero-width replications.
    logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i = {{52{in_inst[31]}}, in_inst[31:20]};
    assign imm_s = {{52{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b = {{51{in_inst[31]}}, in_inst[31], in_inst[7],
                    in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u = {{32{in_inst[31]}}, in_inst[31:12], 12'b0};
    assign imm_j = {{43{in_inst[31]}}, in_inst[31], in_inst[19:12],
                    in_inst[20], in_inst[30:21], 1'b0};

    // Base integer ALU op from funct3; use_sub/use_sra come from inst[30].
    function automatic logic [4:0] base_alu(input logic [2:0] f3,
                                            input logic use_sub,
                                            input logic use_sra);
        case (f3)
            3'b000:  base_alu = use_sub ? ALU_SUB : ALU_ADD;
            3'b001:  base_alu = ALU_SLL;
            3'b010:  base_alu = ALU_SLT;
            3'b011:  base_alu = ALU_SLTU;
            3'b100:  base_alu = ALU_XOR;
            3'b101:  base_alu = use_sra ? ALU_SRA : ALU_SRL;
            3'b110:  base_alu = ALU_OR;
            default: base_alu = ALU_AND;
        endcase
    endfunction

    logic        rs1_used, rs2_used, has_rd;
    logic [4:0]  dec_alu;
    op1_sel_t    op1_sel;
    op2_sel_t    op2_sel;
    logic [63:0] dec_imm64;
    logic        dec_mem_rd, dec_mem_wr, dec_mem_ls, dec_word;
    logic [7:0]  dec_bj;
    logic        dec_illegal;

    always_comb begin
        rs1_used    = 1'b0;
        rs2_used    = 1'b0;
        has_rd      = 1'b0;
        dec_alu     = ALU_ADD;
        op1_sel     = OP1_RS1;
        op2_sel     = OP2_IMM;
        dec_imm64   = 64'd0;
        dec_mem_rd  = 1'b0;
        dec_mem_wr  = 1'b0;
        dec_mem_ls  = 1'b0;
        dec_word    = 1'b0;
        dec_bj      = 8'd0;
        dec_illegal = 1'b0;
        case (opcode)
            OPC_LOAD: begin
                rs1_used   = 1'b1;
                has_rd     = 1'b1;
                dec_imm64  = imm_i;
                dec_mem_rd = 1'b1;
                dec_mem_ls = 1'b1;
                // ld and lwu only exist on RV64
                if (XLEN == 32 && (funct3 == 3'b011 || funct3 == 3'b110))
                    dec_illegal = 1'b1;
            end
            OPC_OP_IMM, OPC_OP_IMM32: begin
                rs1_used  = 1'b1;
                has_rd    = 1'b1;
                dec_imm64 = imm_i;
                dec_alu   = base_alu(funct3, 1'b0, in_inst[30]);
                dec_word  = (opcode == OPC_OP_IMM32);
                if (XLEN == 32) begin
                    if (opcode == OPC_OP_IMM32)
                        dec_illegal = 1'b1;
                    // shamt[5] is reserved on RV32
                    if (funct3[1:0] == 2'b01 && in_inst[25])
                        dec_illegal = 1'b1;
                end
            end
            OPC_OP, OPC_OP32: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                has_rd   = 1'b1;
                op2_sel  = OP2_RS2;
                dec_word = (opcode == OPC_OP32);
                if (funct7 == 7'h01) begin
                    dec_alu = ALU_MUL + {2'b00, funct3};
                    if (M_EXT == 0)
                        dec_illegal = 1'b1;
                end else begin
                    dec_alu = base_alu(funct3, in_inst[30], in_inst[30]);
                end
                if (XLEN == 32 && opcode == OPC_OP32)
                    dec_illegal = 1'b1;
            end
            OPC_STORE: begin
                rs1_used   = 1'b1;
                rs2_used   = 1'b1;
                dec_imm64  = imm_s;
                dec_mem_wr = 1'b1;
                dec_mem_ls = 1'b1;
                if (XLEN == 32 && funct3 == 3'b011)
                    dec_illegal = 1'b1;
            end
            OPC_AUIPC: begin
                has_rd    = 1'b1;
                dec_imm64 = imm_u;
                op1_sel   = OP1_PC;
            end
            OPC_LUI: begin
                has_rd    = 1'b1;
                dec_imm64 = imm_u;
                op1_sel   = OP1_ZERO;
            end
            OPC_BRANCH: begin
                rs1_used  = 1'b1;
                rs2_used  = 1'b1;
                dec_imm64 = imm_b;
                op2_sel   = OP2_RS2;
                case (funct3)
                    3'b000:  begin dec_alu = ALU_XOR;  dec_bj = 8'h01; end
                    3'b001:  begin dec_alu = ALU_XOR;  dec_bj = 8'h02; end
                    3'b100:  begin dec_alu = ALU_SLT;  dec_bj = 8'h04; end
                    3'b101:  begin dec_alu = ALU_SLT;  dec_bj = 8'h08; end
                    3'b110:  begin dec_alu = ALU_SLTU; dec_bj = 8'h10; end
                    3'b111:  begin dec_alu = ALU_SLTU; dec_bj = 8'h20; end
                    default: ;
                endcase
            end
            OPC_JALR: begin
                rs1_used  = 1'b1;
                has_rd    = 1'b1;
                dec_imm64 = imm_i;
                op1_sel   = OP1_PC;
                op2_sel   = OP2_LINK;
                dec_bj    = 8'h40;
            end
            OPC_JAL: begin
                has_rd    = 1'b1;
                dec_imm64 = imm_j;
                op1_sel   = OP1_PC;
                op2_sel   = OP2_LINK;
                dec_bj    = 8'h80;
            end
            OPC_FENCE, OPC_SYSTEM: begin
                dec_imm64 = imm_i;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    logic [XLEN-1:0] dec_imm, dec_op1, dec_op2;

    assign dec_imm = dec_imm64[XLEN-1:0];

    always_comb begin
        case (op1_sel)
            OP1_PC:   dec_op1 = in_pc;
            OP1_ZERO: dec_op1 = '0;
            default:  dec_op1 = rs1_data;
        endcase
        case (op2_sel)
            OP2_RS2:  dec_op2 = rs2_data;
            OP2_LINK: dec_op2 = XLEN'(4);
            default:  dec_op2 = dec_imm;
        endcase
    end

    assign rs1_addr = rs1_used ? in_inst[19:15] : 5'd0;
    assign rs2_addr = rs2_used ? in_inst[24:20] : 5'd0;

    // Unused sources read address 0, so comparing against the gated
    // addresses covers the "source is used" qualification.
    logic hazard;
    assign hazard = in_valid & ex_is_load & (ex_rd != 5'd0) &
                    ((ex_rd == rs1_addr) | (ex_rd == rs2_addr));

    logic valid_reg;
    logic accept;

    assign in_ready = rst_n & (~valid_reg | out_ready) & ~hazard & ~flush;
    assign accept   = in_valid & in_ready;

    logic [XLEN-1:0] pc_reg, op1_reg, op2_reg, imm_reg;
    logic [4:0]      rd_reg, alu_reg;
    logic            rd_wen_reg, mem_rd_reg, mem_wr_reg, mem_uns_reg;
    logic            word_reg, illegal_reg;
    logic [1:0]      mem_size_reg;
    logic [7:0]      bj_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_reg    <= 1'b0;
            pc_reg       <= '0;
            op1_reg      <= '0;
            op2_reg      <= '0;
            imm_reg      <= '0;
            rd_reg       <= '0;
            alu_reg      <= '0;
            rd_wen_reg   <= 1'b0;
            mem_rd_reg   <= 1'b0;
            mem_wr_reg   <= 1'b0;
            mem_size_reg <= '0;
            mem_uns_reg  <= 1'b0;
            word_reg     <= 1'b0;
            bj_reg       <= '0;
            illegal_reg  <= 1'b0;
        end else if (flush) begin
            valid_reg <= 1'b0;
        end else if (accept) begin
            valid_reg    <= 1'b1;
            pc_reg       <= in_pc;
            op1_reg      <= dec_op1;
            op2_reg      <= dec_op2;
            imm_reg      <= dec_imm;
            rd_reg       <= in_inst[11:7];
            alu_reg      <= dec_alu;
            // an illegal instruction must not change architectural state
            rd_wen_reg   <= has_rd & (in_inst[11:7] != 5'd0) & ~dec_illegal;
            mem_rd_reg   <= dec_mem_rd & ~dec_illegal;
            mem_wr_reg   <= dec_mem_wr & ~dec_illegal;
            mem_size_reg <= dec_mem_ls ? funct3[1:0] : 2'b00;
            mem_uns_reg  <= dec_mem_ls & funct3[2];
            word_reg     <= dec_word;
            bj_reg       <= dec_illegal ? 8'd0 : dec_bj;
            illegal_reg  <= dec_illegal;
        end else if (out_ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign out_valid        = valid_reg;
    assign out_pc           = pc_reg;
    assign out_op1          = op1_reg;
    assign out_op2          = op2_reg;
    assign out_imm          = imm_reg;
    assign out_rd           = rd_reg;
    assign out_rd_wen       = rd_wen_reg;
    assign out_alu_op       = alu_reg;
    assign out_mem_rd       = mem_rd_reg;
    assign out_mem_wr       = mem_wr_reg;
    assign out_mem_size     = mem_size_reg;
    assign out_mem_unsigned = mem_uns_reg;
    assign out_word         = word_reg;
    assign out_bj           = bj_reg;
    assign out_illegal      = illegal_reg;

endmodule

// File: tb/tb_id_pipe_stage.sv
// tb_id_pipe_stage -- bench for id_pipe_stage.
// Three instances share the stimulus: u0 XLEN=64/M_EXT=0, u1 XLEN=64/M_EXT=1,
// u2 XLEN=32/M_EXT=0.  Directed steps exercise handshake, hazards, stalls,
// flush and reset; random instructions are checked against a mnemonic-level
// reference decoder and a valid/ready scoreboard.
module tb_id_pipe_stage;

    typedef struct packed {
        logic [4:0]  rs1a;
        logic [4:0]  rs2a;
        logic [4:0]  rd;
        logic        rd_wen;
        logic [4:0]  alu;
        logic [63:0] op1;
        logic [63:0] op2;
        logic [63:0] imm;
        logic [63:0] pc;
        logic        mem_rd;
        logic        mem_wr;
        logic [1:0]  size;
        logic        uns;
        logic        word;
        logic [7:0]  bj;
        logic        ill;
    } dec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, flush, ex_is_load, out_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc, rs1_data, rs2_data;
    logic [4:0]  ex_rd;

    logic        in_ready_a[3], ov_a[3], wen_a[3], mrd_a[3], mwr_a[3];
    logic        mun_a[3], word_a[3], ill_a[3];
    logic [4:0]  rs1a_a[3], rs2a_a[3], rd_a[3], alu_a[3];
    logic [1:0]  msz_a[3];
    logic [7:0]  bj_a[3];
    logic [63:0] pc_a[2], op1_a[2], op2_a[2], imm_a[2];
    logic [31:0] pc32, op132, op232, imm32;

    id_pipe_stage #(.XLEN(64), .M_EXT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a[0]),
        .in_inst(in_inst), .in_pc(in_pc), .rs1_addr(rs1a_a[0]), .rs2_addr(rs2a_a[0]),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .out_valid(ov_a[0]), .out_ready(out_ready),
        .out_pc(pc_a[0]), .out_op1(op1_a[0]), .out_op2(op2_a[0]), .out_imm(imm_a[0]),
        .out_rd(rd_a[0]), .out_rd_wen(wen_a[0]), .out_alu_op(alu_a[0]),
        .out_mem_rd(mrd_a[0]), .out_mem_wr(mwr_a[0]), .out_mem_size(msz_a[0]),
        .out_mem_unsigned(mun_a[0]), .out_word(word_a[0]), .out_bj(bj_a[0]),
        .out_illegal(ill_a[0]));

    id_pipe_stage #(.XLEN(64), .M_EXT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a[1]),
        .in_inst(in_inst), .in_pc(in_pc), .rs1_addr(rs1a_a[1]), .rs2_addr(rs2a_a[1]),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .out_valid(ov_a[1]), .out_ready(out_ready),
        .out_pc(pc_a[1]), .out_op1(op1_a[1]), .out_op2(op2_a[1]), .out_imm(imm_a[1]),
        .out_rd(rd_a[1]), .out_rd_wen(wen_a[1]), .out_alu_op(alu_a[1]),
        .out_mem_rd(mrd_a[1]), .out_mem_wr(mwr_a[1]), .out_mem_size(msz_a[1]),
        .out_mem_unsigned(mun_a[1]), .out_word(word_a[1]), .out_bj(bj_a[1]),
        .out_illegal(ill_a[1]));

    id_pipe_stage #(.XLEN(32), .M_EXT(0)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a[2]),
        .in_inst(in_inst), .in_pc(in_pc[31:0]), .rs1_addr(rs1a_a[2]), .rs2_addr(rs2a_a[2]),
        .rs1_data(rs1_data[31:0]), .rs2_data(rs2_data[31:0]), .flush(flush),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .out_valid(ov_a[2]), .out_ready(out_ready),
        .out_pc(pc32), .out_op1(op132), .out_op2(op232), .out_imm(imm32),
        .out_rd(rd_a[2]), .out_rd_wen(wen_a[2]), .out_alu_op(alu_a[2]),
        .out_mem_rd(mrd_a[2]), .out_mem_wr(mwr_a[2]), .out_mem_size(msz_a[2]),
        .out_mem_unsigned(mun_a[2]), .out_word(word_a[2]), .out_bj(bj_a[2]),
        .out_illegal(ill_a[2]));

    dec_t obs[3];

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            obs[k]        = '0;
            obs[k].rs1a   = rs1a_a[k];
            obs[k].rs2a   = rs2a_a[k];
            obs[k].rd     = rd_a[k];
            obs[k].rd_wen = wen_a[k];
            obs[k].alu    = alu_a[k];
            obs[k].mem_rd = mrd_a[k];
            obs[k].mem_wr = mwr_a[k];
            obs[k].size   = msz_a[k];
            obs[k].uns    = mun_a[k];
            obs[k].word   = word_a[k];
            obs[k].bj     = bj_a[k];
            obs[k].ill    = ill_a[k];
        end
        for (int k = 0; k < 2; k++) begin
            obs[k].pc  = pc_a[k];
            obs[k].op1 = op1_a[k];
            obs[k].op2 = op2_a[k];
            obs[k].imm = imm_a[k];
        end
        obs[2].pc  = {32'd0, pc32};
        obs[2].op1 = {32'd0, op132};
        obs[2].op2 = {32'd0, op232};
        obs[2].imm = {32'd0, imm32};
    end

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        vec_cnt++;
        assert (o === e) else begin
            err_cnt++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
        end
    endtask

    // Reference decoder, written per instruction class from the ISA rules.
    function automatic dec_t model(input logic [31:0] ins, input logic [63:0] pc,
                                   input logic [63:0] r1, input logic [63:0] r2,
                                   input bit mext, input bit x32);
        dec_t d;
        bit u1, u2, hr, ill, reg_op2, link;
        logic [63:0] imm, ii, si, bi, ui, ji;
        logic [2:0] f3;
        int alu_tab[8] = '{0, 7, 2, 3, 4, 8, 5, 6};
        f3 = ins[14:12];
        ii = {{52{ins[31]}}, ins[31:20]};
        si = {{52{ins[31]}}, ins[31:25], ins[11:7]};
        bi = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        ui = {{32{ins[31]}}, ins[31:12], 12'b0};
        ji = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        d = '0; u1 = 0; u2 = 0; hr = 0; ill = 0; reg_op2 = 0; link = 0; imm = 0;
        d.op1 = r1;
        d.pc  = pc;
        d.rd  = ins[11:7];
        case (ins[6:0])
            7'h03: begin
                u1 = 1; hr = 1; imm = ii; d.mem_rd = 1; d.size = f3[1:0]; d.uns = f3[2];
                if (x32 && (f3 == 3 || f3 == 6)) ill = 1;
            end
            7'h13, 7'h1b: begin
                u1 = 1; hr = 1; imm = ii; d.alu = 5'(alu_tab[f3]);
                if (f3 == 5 && ins[30]) d.alu = 9;
                if (ins[6:0] == 7'h1b) begin d.word = 1; if (x32) ill = 1; end
                if (x32 && (f3 == 1 || f3 == 5) && ins[25]) ill = 1;
            end
            7'h33, 7'h3b: begin
                u1 = 1; u2 = 1; hr = 1; reg_op2 = 1;
                if (ins[31:25] == 7'h01) begin
                    d.alu = 5'(10 + f3);
                    if (!mext) ill = 1;
                end else begin
                    d.alu = 5'(alu_tab[f3]);
                    if (f3 == 0 && ins[30]) d.alu = 1;
                    if (f3 == 5 && ins[30]) d.alu = 9;
                end
                if (ins[6:0] == 7'h3b) begin d.word = 1; if (x32) ill = 1; end
            end
            7'h23: begin
                u1 = 1; u2 = 1; imm = si; d.mem_wr = 1; d.size = f3[1:0]; d.uns = f3[2];
                if (x32 && f3 == 3) ill = 1;
            end
            7'h17: begin hr = 1; imm = ui; d.op1 = pc; end
            7'h37: begin hr = 1; imm = ui; d.op1 = 0; end
            7'h63: begin
                u1 = 1; u2 = 1; imm = bi; reg_op2 = 1;
                case (f3)
                    0: begin d.alu = 4; d.bj = 8'h01; end
                    1: begin d.alu = 4; d.bj = 8'h02; end
                    4: begin d.alu = 2; d.bj = 8'h04; end
                    5: begin d.alu = 2; d.bj = 8'h08; end
                    6: begin d.alu = 3; d.bj = 8'h10; end
                    7: begin d.alu = 3; d.bj = 8'h20; end
                    default: ;
                endcase
            end
            7'h67: begin u1 = 1; hr = 1; imm = ii; d.op1 = pc; link = 1; d.bj = 8'h40; end
            7'h6f: begin hr = 1; imm = ji; d.op1 = pc; link = 1; d.bj = 8'h80; end
            7'h0f, 7'h73: imm = ii;
            default: ill = 1;
        endcase
        d.imm  = imm;
        d.op2  = reg_op2 ? r2 : (link ? 64'd4 : imm);
        d.rs1a = u1 ? ins[19:15] : 5'd0;
        d.rs2a = u2 ? ins[24:20] : 5'd0;
        d.rd_wen = hr && (ins[11:7] != 0) && !ill;
        if (ill) begin d.mem_rd = 0; d.mem_wr = 0; d.bj = 0; end
        d.ill = ill;
        if (x32) begin
            d.op1 = {32'd0, d.op1[31:0]};
            d.op2 = {32'd0, d.op2[31:0]};
            d.imm = {32'd0, d.imm[31:0]};
            d.pc  = {32'd0, d.pc[31:0]};
        end
        return d;
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [31:0] w;
        logic [6:0] opcs[14] = '{7'h03, 7'h13, 7'h1b, 7'h17, 7'h37, 7'h23, 7'h33,
                                 7'h3b, 7'h63, 7'h67, 7'h6f, 7'h0f, 7'h73, 7'h2b};
        w = $urandom;
        w[6:0] = opcs[$urandom_range(0, 13)];
        case (w[6:0])
            7'h33, 7'h3b: begin
                case ($urandom_range(0, 2))
                    0: w[31:25] = 7'h00;
                    1: w[31:25] = 7'h20;
                    default: w[31:25] = 7'h01;
                endcase
            end
            7'h13, 7'h1b: if (w[13:12] == 2'b01) w[31:26] = ($urandom_range(0, 1) != 0) ? 6'b010000 : 6'b000000;
            7'h63: if (w[14:13] == 2'b01) w[14] = 1'b1;
            default: ;
        endcase
        return w;
    endfunction

    dec_t exp_now[3];
    dec_t held[3];

    task automatic set_exp();
        for (int k = 0; k < 3; k++)
            exp_now[k] = model(in_inst, in_pc, rs1_data, rs2_data, k == 1, k == 2);
    endtask

    task automatic cmp_reg(input string tag, input int k, input dec_t e);
        string t;
        t = $sformatf("%s.u%0d", tag, k);
        chk({t, ".rd"},     64'(obs[k].rd),     64'(e.rd));
        chk({t, ".rd_wen"}, 64'(obs[k].rd_wen), 64'(e.rd_wen));
        chk({t, ".alu"},    64'(obs[k].alu),    64'(e.alu));
        chk({t, ".op1"},    obs[k].op1,         e.op1);
        chk({t, ".op2"},    obs[k].op2,         e.op2);
        chk({t, ".imm"},    obs[k].imm,         e.imm);
        chk({t, ".pc"},     obs[k].pc,          e.pc);
        chk({t, ".mem_rd"}, 64'(obs[k].mem_rd), 64'(e.mem_rd));
        chk({t, ".mem_wr"}, 64'(obs[k].mem_wr), 64'(e.mem_wr));
        chk({t, ".size"},   64'(obs[k].size),   64'(e.size));
        chk({t, ".uns"},    64'(obs[k].uns),    64'(e.uns));
        chk({t, ".word"},   64'(obs[k].word),   64'(e.word));
        chk({t, ".bj"},     64'(obs[k].bj),     64'(e.bj));
        chk({t, ".ill"},    64'(obs[k].ill),    64'(e.ill));
    endtask

    task automatic cmp_comb(input string tag, input int k, input dec_t e);
        chk($sformatf("%s.u%0d.rs1a", tag, k), 64'(obs[k].rs1a), 64'(e.rs1a));
        chk($sformatf("%s.u%0d.rs2a", tag, k), 64'(obs[k].rs2a), 64'(e.rs2a));
    endtask

    task automatic chk_valid(input string tag, input logic e);
        for (int k = 0; k < 3; k++)
            chk($sformatf("%s.u%0d.out_valid", tag, k), 64'(ov_a[k]), 64'(e));
    endtask

    task automatic chk_ready(input string tag, input logic e);
        for (int k = 0; k < 3; k++)
            chk($sformatf("%s.u%0d.in_ready", tag, k), 64'(in_ready_a[k]), 64'(e));
    endtask

    task automatic cmp_all(input string tag);
        for (int k = 0; k < 3; k++) cmp_reg(tag, k, exp_now[k]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit exp_valid, haz, rdy, acc;
        rst_n = 0; in_valid = 0; flush = 0; ex_is_load = 0; ex_rd = 0; out_ready = 1;
        in_inst = 0; in_pc = 0; rs1_data = 0; rs2_data = 0;
        tick();
        tick();

        // reset state, in_ready held low during reset
        in_valid = 1; in_inst = 32'h00500093; #1;
        chk_ready("reset", 1'b0);
        chk_valid("reset", 1'b0);
        for (int k = 0; k < 3; k++) cmp_reg("reset", k, '0);
        $display("step reset");

        // addi x1,x0,5
        rst_n = 1; in_pc = 64'h80000000; rs1_data = 0; rs2_data = 64'hdead; #1;
        chk_ready("addi", 1'b1);
        set_exp();
        for (int k = 0; k < 3; k++) cmp_comb("addi", k, exp_now[k]);
        tick();
        chk_valid("addi", 1'b1);
        cmp_all("addi");
        chk("addi.rd",  64'(rd_a[0]),  64'd1);
        chk("addi.wen", 64'(wen_a[0]), 64'd1);
        chk("addi.alu", 64'(alu_a[0]), 64'd0);
        chk("addi.op1", op1_a[0], 64'd0);
        chk("addi.op2", op2_a[0], 64'd5);
        chk("addi.pc",  pc_a[0],  64'h80000000);
        $display("step addi x1,x0,5");

        // load-use hazard on add x3,x2,x1
        ex_is_load = 1; ex_rd = 2; in_inst = 32'h001101b3; in_pc = 64'h80000004;
        rs1_data = 64'h11; rs2_data = 64'h1234; #1;
        chk_ready("hazard", 1'b0);
        tick();
        chk_valid("hazard", 1'b0);
        ex_rd = 3; #1;
        chk("nohazard_rd3.in_ready", 64'(in_ready_a[0]), 64'd1);
        ex_is_load = 0; ex_rd = 0;
        set_exp();
        tick();
        chk_valid("hazard_release", 1'b1);
        cmp_all("hazard_release");
        chk("hazard_release.op2", op2_a[0], 64'h1234);
        held = exp_now;
        $display("step hazard add x3,x2,x1");

        // downstream stall for three cycles
        out_ready = 0; in_inst = 32'h00c58613; in_pc = 64'h80000008;
        rs1_data = {$urandom, $urandom};
        for (int c = 0; c < 3; c++) begin
            #1;
            chk_ready("stall", 1'b0);
            tick();
            chk_valid("stall", 1'b1);
            for (int k = 0; k < 3; k++) cmp_reg("stall", k, held[k]);
            $display("step stall cycle %0d", c);
        end
        out_ready = 1; #1;
        chk_ready("stall_release", 1'b1);
        set_exp();
        tick();
        cmp_all("stall_release");
        $display("step stall release addi x12,x11,12");

        // mul x0,x1,x2
        in_inst = 32'h02208033; in_pc = 64'h8000000c;
        rs1_data = {$urandom, $urandom}; rs2_data = {$urandom, $urandom};
        set_exp();
        tick();
        cmp_all("mul");
        chk("mul.m0.ill", 64'(ill_a[0]), 64'd1);
        chk("mul.m0.wen", 64'(wen_a[0]), 64'd0);
        chk("mul.m1.alu", 64'(alu_a[1]), 64'd10);
        chk("mul.m1.ill", 64'(ill_a[1]), 64'd0);
        $display("step mul x0,x1,x2");

        // ld on RV32
        in_inst = 32'h0000b103; in_pc = 64'h80000010;
        set_exp();
        tick();
        cmp_all("ld");
        chk("ld.x32.ill", 64'(ill_a[2]), 64'd1);
        chk("ld.x64.ill", 64'(ill_a[0]), 64'd0);
        $display("step ld x2,0(x1)");

        // jal x1,+8 on RV32
        in_inst = 32'h008000ef; in_pc = 64'h80000014;
        set_exp();
        tick();
        cmp_all("jal");
        chk("jal.x32.op1", 64'(op132), 64'h80000014);
        chk("jal.x32.op2", 64'(op232), 64'd4);
        chk("jal.x32.imm", 64'(imm32), 64'd8);
        chk("jal.x32.bj",  64'(bj_a[2]), 64'h80);
        $display("step jal x1,+8");

        // flush with in_valid, then reset in the middle of a stall
        flush = 1; in_inst = 32'h00500093; #1;
        chk_ready("flush", 1'b0);
        tick();
        chk_valid("flush", 1'b0);
        flush = 0;
        tick();
        chk_valid("post_flush_accept", 1'b1);
        out_ready = 0; in_inst = 32'h001101b3;
        tick();
        chk_valid("pre_reset_stall", 1'b1);
        rst_n = 0; #1;
        chk_ready("reset_mid_stall", 1'b0);
        tick();
        chk_valid("reset_mid_stall", 1'b0);
        for (int k = 0; k < 3; k++) cmp_reg("reset_mid_stall", k, '0);
        $display("step flush and reset mid-stall");
        rst_n = 1; in_valid = 0; out_ready = 1;
        tick();
        chk_valid("idle", 1'b0);

        // randomized traffic against the reference decoder and handshake model
        exp_valid = 0;
        for (int i = 0; i < 150; i++) begin
            in_valid   = ($urandom_range(0, 7) != 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            ex_is_load = ($urandom_range(0, 3) == 0);
            ex_rd      = 5'($urandom);
            in_inst    = gen_inst();
            in_pc      = {$urandom, $urandom} & ~64'd3;
            rs1_data   = {$urandom, $urandom};
            rs2_data   = {$urandom, $urandom};
            set_exp();
            #1;
            acc = 0;
            for (int k = 0; k < 3; k++) begin
                haz = in_valid && ex_is_load && (ex_rd != 0) &&
                      (ex_rd == exp_now[k].rs1a || ex_rd == exp_now[k].rs2a);
                rdy = (!exp_valid || out_ready) && !haz;
                chk($sformatf("rnd%0d.u%0d.in_ready", i, k), 64'(in_ready_a[k]), 64'(rdy));
                cmp_comb($sformatf("rnd%0d", i), k, exp_now[k]);
                acc = in_valid && rdy;
            end
            tick();
            if (acc) begin
                exp_valid = 1;
                held = exp_now;
            end else if (out_ready) begin
                exp_valid = 0;
            end
            chk_valid($sformatf("rnd%0d", i), exp_valid);
            if (exp_valid)
                for (int k = 0; k < 3; k++) cmp_reg($sformatf("rnd%0d", i), k, held[k]);
            $display("vec %0d inst=%08h accepted=%0d out_ready=%0d", i, in_inst, acc, out_ready);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/id_pipe_stage.md
ID_PIPE_STAGE -- requirements
Module: id_pipe_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width; legal values 32 and 64 only.
REQ-002 SHALL have parameter M_EXT, default 0; 1 enables RV M-extension decode.
REQ-003 SHALL have ports: clk  in  1  rising-edge clock.
REQ-004 SHALL have ports: rst_n  in  1  reset; one clock, reset synchronous and active-low.
REQ-005 SHALL have upstream ports: in_valid in 1; in_ready out 1; in_inst in 32; in_pc in XLEN.
REQ-006 SHALL have regfile ports: rs1_addr out 5; rs2_addr out 5; rs1_data in XLEN; rs2_data in XLEN (combinational read).
REQ-007 SHALL have control ports: flush in 1 (kill stage); ex_is_load in 1, ex_rd in 5 (instruction now in EX).
REQ-008 SHALL have downstream ports: out_valid out 1; out_ready in 1; out_pc, out_op1, out_op2, out_imm out XLEN each.
REQ-009 SHALL have downstream ports: out_rd out 5; out_rd_wen out 1; out_alu_op out 5; out_mem_rd out 1; out_mem_wr out 1; out_mem_size out 2; out_mem_unsigned out 1; out_word out 1; out_bj out 8; out_illegal out 1.

Function
REQ-010 SHALL decode RV32I/RV64I base (load, op-imm, auipc, op-imm-32, store, op, lui, op-32, branch, jalr, jal, fence, system) combinationally from in_inst, registered in one ID/EX register; latency 1 cycle.
REQ-011 SHALL drive rs1_addr/rs2_addr = inst[19:15]/inst[24:20] when the format reads that source, else 0.
REQ-012 SHALL encode out_alu_op: 0 ADD,1 SUB,2 SLT,3 SLTU,4 XOR,5 OR,6 AND,7 SLL,8 SRL,9 SRA,10 MUL,11 MULH,12 MULHSU,13 MULHU,14 DIV,15 DIVU,16 REM,17 REMU; branches: beq/bne XOR, blt/bge SLT, bltu/bgeu SLTU; load/store/lui/auipc/jal/jalr ADD.
REQ-013 SHALL select op1: pc for auipc/jal/jalr, 0 for lui, rs1_data otherwise; op2: rs2_data for R/B, 4 for jal/jalr (link), imm otherwise.
REQ-014 SHALL sign-extend immediates (I,S,B,U,J) to XLEN; U imm = inst[31:12]<<12 sign-extended; out_imm for jalr = I imm, target computed downstream.
REQ-015 SHALL set out_bj one-hot {jal,jalr,bgeu,bltu,bge,blt,bne,beq} (bit7..0), zero otherwise.
REQ-016 SHALL set out_mem_size = funct3[1:0], out_mem_unsigned = funct3[2] for loads/stores; out_word = 1 for op-32/op-imm-32.
REQ-017 SHALL force out_rd_wen = 0 when rd = 0 or instruction has no destination.
REQ-018 SHALL flag out_illegal (rd_wen, mem_rd, mem_wr, out_bj forced 0) for: unknown opcode; funct7=0x01 when M_EXT=0; when XLEN=32, op-32/op-imm-32, ld/sd/lwu, shamt[5]=1.
REQ-019 SHALL assert in_ready = (~out_valid | out_ready) & ~hazard & ~flush.
REQ-020 SHALL define hazard = in_valid & ex_is_load & ex_rd != 0 & ((rs1 used & ex_rd == rs1) | (rs2 used & ex_rd == rs2)).
REQ-021 SHALL load ID/EX register and set out_valid = 1 on in_valid & in_ready.
REQ-022 SHALL clear out_valid (bubble) when out_ready = 1 and no transfer accepted (hazard or in_valid = 0).
REQ-023 SHALL hold all out_* stable while out_valid & ~out_ready.
REQ-024 SHALL on flush clear out_valid next cycle, priority over accept and hold; data need not clear.

Reset
REQ-025 SHALL on rst_n = 0 at clk edge clear out_valid and all registered out_* to 0, regardless of in-flight transfer.
REQ-026 SHALL hold in_ready = 0 while rst_n = 0.

Verification
REQ-027 addi x1,x0,5 (0x00500093), pc 0x80000000 -> next cycle out_valid=1, rd=1, rd_wen=1, alu_op=0, op1=0, op2=5, out_pc=0x80000000.
REQ-028 ex_is_load=1, ex_rd=2, in add x3,x2,x1 (0x001101b3) -> in_ready=0, out_valid=0 next cycle; drop ex_is_load -> accepted, op2=rs2_data.
REQ-029 out_ready=0 for 3 cycles with valid output -> outputs unchanged, in_ready=0; out_ready=1 -> next instruction loaded.
REQ-030 mul x0,x1,x2 (0x02208033), M_EXT=0 -> out_illegal=1, rd_wen=0; M_EXT=1 -> alu_op=10, illegal=0.
REQ-031 XLEN=32, ld (0x0000b103) -> out_illegal=1; jal x1,+8 (0x008000ef) -> op1=pc, op2=4, imm=8, out_bj=0x80.
REQ-032 flush with in_valid=1, then rst_n=0 mid-stall -> out_valid=0 following cycle; all outputs 0 after reset.
